pipe_result_collector: RTL and testbench
========================================

// Module: pipe_result_collector
// PURPOSE
//   Consumer end of the arithmetic pipeline (pipe_ex): the stimulus side launches
//   operands a/b/c/d and pulses issue. This block tracks each issue through a
//   LAT-deep valid delay line, captures the matching f result, and buffers it in a
//   DEPTH-entry FIFO with a valid/ready output. It also keeps a running sum and a
//   sticky overflow flag for system-level checking.
// PARAMETERS
//   N     10  width of pipeline result f_in / out_data
//   LAT   3   pipeline latency in clocks, issue edge to capture edge (LAT >= 1)
//   DEPTH 8   FIFO entries, power of two, >= 2
//   SUMW  16  running-sum width, SUMW >= N
// PORTS
//   clk       in   1              rising-edge clock
//   rst_n     in   1              asynchronous active-low reset
//   issue     in   1              operands launched into pipeline this cycle
//   f_in      in   N              pipeline result bus
//   clr       in   1              sync clear of sum and overflow (FIFO untouched)
//   out_data  out  N              FIFO head (show-ahead)
//   out_valid out  1              FIFO non-empty
//   out_ready in   1              consumer accepts head this edge
//   count     out  $clog2(DEPTH)+1  FIFO occupancy
//   overflow  out  1              sticky: a result was dropped
//   sum       out  SUMW           sum of accepted results, mod 2^SUMW
// BEHAVIOUR
// - Reset (rst_n=0, async, any time): delay line, FIFO pointers, count, sum,
//   overflow all 0; out_valid=0, out_data=0. In-flight issues are discarded.
// - Delay line: v[0]<=issue; v[i]<=v[i-1]. issue sampled at edge t => f_in
//   captured at edge t+LAT (v[LAT-1]=1 during preceding cycle). Back-to-back
//   issues every cycle are supported; each yields one capture.
// - Capture event cap = v[LAT-1]. Write accepted if count<DEPTH, or count==DEPTH
//   and pop this same edge. Otherwise result dropped, overflow<=1.
// - Pop = out_valid & out_ready. out_ready while empty is ignored.
// - Simultaneous cap and pop: count unchanged; if count was 1 head advances to
//   the new entry (out_valid stays 1, out_data shows new value next cycle).
// - Empty FIFO capture: out_valid rises the cycle after the capture edge (no
//   bypass; latency issue->out_valid = LAT+1 edges).
// - out_data = mem[rd_ptr], registered storage; holds last value when empty.
// - Pointers log2(DEPTH) bits, wrap naturally; count is separate full-width reg.
// - sum <= sum + zero-extended f_in on each accepted write; wraps mod 2^SUMW.
//   Dropped results are not summed.
// - clr: sum<=0, overflow<=0 at edge; if a write is accepted on the same edge,
//   sum<=f_in (clr then add). clr does not affect FIFO or delay line.
// - overflow set and clr same edge: overflow<=1 (set wins).
// TESTING
// 1 Reset: rst_n=0 mid-stream with 2 in flight, 3 stored -> all outputs 0,
//   no captures appear after release.
// 2 Latency: issue at edge 2, f_in=90 at edge 5 (LAT=3) -> out_valid=1 after
//   edge 5, out_data=90, count=1, sum=90.
// 3 Streaming: issue 8 consecutive cycles, f_in=1..8, out_ready=1 -> out_data
//   1..8 in order, count<=1 throughout, sum=36, overflow=0.
// 4 Full: out_ready=0, 9 issues -> count=8, overflow=1, sum=sum of first 8;
//   9th with pop on same edge (repeat) -> accepted, overflow stays 0.
// 5 Wrap: 20 results with random out_ready -> exact FIFO order; sum wraps when
//   SUMW=8 and results 200,100 -> sum=44.
// 6 clr: clr with concurrent accepted f_in=7 and overflow=1 -> sum=7, overflow=0.

Source files
------------

// File: rtl/pipe_result_collector_if.sv
// Result-side bundle between the stimulus/consumer and the collector.
// Carries issue/result inputs, FIFO head handshake and the checking outputs.
interface pipe_result_collector_if #(
  parameter int N     = 10,
  parameter int DEPTH = 8,
  parameter int SUMW  = 16
);
  logic                     issue;
  logic [N-1:0]             f_in;
  logic                     clr;
  logic [N-1:0]             out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [$clog2(DEPTH):0]   count;
  logic                     overflow;
  logic [SUMW-1:0]          sum;

  modport master (
    output issue, f_in, clr, out_ready,
    input  out_data, out_valid, count, overflow, sum
  );

  modport slave (
    input  issue, f_in, clr, out_ready,
    output out_data, out_valid, count, overflow, sum
  );
endinterface

// File: rtl/pipe_result_collector.sv
// Collects pipe_ex results LAT clocks after issue into a DEPTH-entry show-ahead FIFO; out_valid rises LAT+1 edges after issue.
// Backpressure: out_ready stalls the head; a capture into a full FIFO without a same-edge pop is dropped and flags overflow.
module pipe_result_collector #(
  parameter int N     = 10,
  parameter int LAT   = 3,
  parameter int DEPTH = 8,
  parameter int SUMW  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pipe_result_collector_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [LAT-1:0]  v;
  logic            cap;
  logic            push;
  logic            pop;
  logic            wr_rdy;
  logic            drop;

  logic [N-1:0]    mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   rd_ptr_nxt;
  logic [AW:0]     count_q;
  logic [AW:0]     count_nxt;
  logic [N-1:0]    head_q;
  logic            rd_vld;

  logic [SUMW-1:0] sum_q;
  logic            ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= '0;
    end else begin
      v[0] <= bus.issue;
      for (int i = 1; i < LAT; i++) begin
        v[i] <= v[i-1];
      end
    end
  end

  assign cap    = v[LAT-1];
  assign rd_vld = (count_q != '0);
  assign pop    = rd_vld & bus.out_ready;
  // A full FIFO still takes the capture when its head leaves on the same edge.
  assign wr_rdy = (count_q != FULL) | pop;
  assign push   = cap & wr_rdy;
  assign drop   = cap & ~wr_rdy;

  assign rd_ptr_nxt = pop ? rd_ptr + 1'b1 : rd_ptr;

  always_comb begin
    count_nxt = count_q;
    if (push && !pop) begin
      count_nxt = count_q + 1'b1;
    end else if (pop && !push) begin
      count_nxt = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      head_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= bus.f_in;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      rd_ptr  <= rd_ptr_nxt;
      count_q <= count_nxt;
      // Registered copy of mem[rd_ptr]; forwards the write when the new head is the slot being written.
      if (count_nxt != '0) begin
        head_q <= (push && (rd_ptr_nxt == wr_ptr)) ? bus.f_in : mem[rd_ptr_nxt];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (bus.clr) begin
        sum_q <= push ? SUMW'(bus.f_in) : '0;
      end else if (push) begin
        sum_q <= sum_q + SUMW'(bus.f_in);
      end
      if (drop) begin
        ovf_q <= 1'b1;
      end else if (bus.clr) begin
        ovf_q <= 1'b0;
      end
    end
  end

  assign bus.out_data  = head_q;
  assign bus.out_valid = rd_vld;
  assign bus.count     = count_q;
  assign bus.overflow  = ovf_q;
  assign bus.sum       = sum_q;

endmodule

// File: tb/tb_pipe_result_collector.sv
// Directed bench for pipe_result_collector: vector table for latency/streaming plus
// hand-written sequences for full, clr, reset, wrap-around and narrow-sum cases.
module tb_pipe_result_collector;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipe_result_collector_if #(.N(10), .DEPTH(8), .SUMW(16)) bus ();
  pipe_result_collector_if #(.N(10), .DEPTH(8), .SUMW(8))  bus8 ();

  pipe_result_collector #(.N(10), .LAT(3), .DEPTH(8), .SUMW(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  pipe_result_collector #(.N(10), .LAT(3), .DEPTH(8), .SUMW(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .bus(bus8)
  );

  typedef struct {
    logic       iss;
    logic [9:0] f;
    logic       rdy;
    logic       clr;
    logic       v;
    logic [9:0] d;
    logic [3:0] cnt;
    logic       o;
    logic [15:0] s;
  } vec_t;

  vec_t        tbl [18];
  int          checks = 0;
  int          errors = 0;
  logic [9:0]  vals [20];
  logic [9:0]  q [$];
  int          pushed;
  int          popped;
  int          n5;
  logic [15:0] esum;
  logic        iss5;
  logic        cap5;
  logic        rdy5;
  logic [9:0]  f5;
  logic [9:0]  exp_head;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic iss, input logic [9:0] f, input logic rdy,
                              input logic c, input logic v, input logic [9:0] d,
                              input logic [3:0] cnt, input logic o, input logic [15:0] s);
    vec_t r;
    r.iss = iss; r.f = f; r.rdy = rdy; r.clr = c;
    r.v = v; r.d = d; r.cnt = cnt; r.o = o; r.s = s;
    return r;
  endfunction

  task automatic cyc(input logic iss, input logic [9:0] f, input logic rdy, input logic c);
    bus.issue = iss;
    bus.f_in = f;
    bus.out_ready = rdy;
    bus.clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.issue = 1'b0;
    bus.f_in = 10'd0;
    bus.out_ready = 1'b0;
    bus.clr = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    bus.issue = 1'b0; bus.f_in = 10'd0; bus.out_ready = 1'b0; bus.clr = 1'b0;
    bus8.issue = 1'b0; bus8.f_in = 10'd0; bus8.out_ready = 1'b0; bus8.clr = 1'b0;

    // Issue at edge 2 -> capture of 90 at edge 5; then 8 back-to-back issues streamed out.
    tbl[0] = mk(1'b0, 10'd0,  1'b0, 1'b0, 1'b0, 10'd0,  4'd0, 1'b0, 16'd0);
    tbl[1] = mk(1'b1, 10'd0,  1'b0, 1'b0, 1'b0, 10'd0,  4'd0, 1'b0, 16'd0);
    tbl[2] = mk(1'b0, 10'd0,  1'b0, 1'b0, 1'b0, 10'd0,  4'd0, 1'b0, 16'd0);
    tbl[3] = mk(1'b0, 10'd55, 1'b0, 1'b0, 1'b0, 10'd0,  4'd0, 1'b0, 16'd0);
    tbl[4] = mk(1'b0, 10'd90, 1'b0, 1'b0, 1'b1, 10'd90, 4'd1, 1'b0, 16'd90);
    tbl[5] = mk(1'b0, 10'd33, 1'b1, 1'b0, 1'b0, 10'd90, 4'd0, 1'b0, 16'd90);
    tbl[6] = mk(1'b1, 10'd0,  1'b1, 1'b1, 1'b0, 10'd90, 4'd0, 1'b0, 16'd0);
    tbl[7] = mk(1'b1, 10'd0,  1'b1, 1'b0, 1'b0, 10'd90, 4'd0, 1'b0, 16'd0);
    tbl[8] = mk(1'b1, 10'd0,  1'b1, 1'b0, 1'b0, 10'd90, 4'd0, 1'b0, 16'd0);
    for (int e = 10; e <= 17; e++) begin
      tbl[e-1] = mk(1'b1 && (e <= 14), 10'(e - 9), 1'b1, 1'b0, 1'b1, 10'(e - 9), 4'd1, 1'b0,
                    16'(((e - 9) * (e - 8)) / 2));
    end
    tbl[17] = mk(1'b0, 10'd0, 1'b1, 1'b0, 1'b0, 10'd8, 4'd0, 1'b0, 16'd36);

    #3;
    chk("reset out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset out_data",  32'(bus.out_data),  32'd0);
    chk("reset count",     32'(bus.count),     32'd0);
    chk("reset overflow",  32'(bus.overflow),  32'd0);
    chk("reset sum",       32'(bus.sum),       32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int k = 0; k < 18; k++) begin
      cyc(tbl[k].iss, tbl[k].f, tbl[k].rdy, tbl[k].clr);
      chk($sformatf("tbl e%0d out_valid", k + 1), 32'(bus.out_valid), 32'(tbl[k].v));
      chk($sformatf("tbl e%0d out_data",  k + 1), 32'(bus.out_data),  32'(tbl[k].d));
      chk($sformatf("tbl e%0d count",     k + 1), 32'(bus.count),     32'(tbl[k].cnt));
      chk($sformatf("tbl e%0d overflow",  k + 1), 32'(bus.overflow),  32'(tbl[k].o));
      chk($sformatf("tbl e%0d sum",       k + 1), 32'(bus.sum),       32'(tbl[k].s));
    end

    // Fill: 9 issues with consumer stalled; 9th result (18) is dropped.
    cyc(1'b0, 10'd0, 1'b0, 1'b1);
    chk("full clr sum", 32'(bus.sum), 32'd0);
    for (int i = 0; i < 12; i++) begin
      cyc(1'b1 && (i < 9), (i >= 3) ? 10'(10 + i - 3) : 10'd0, 1'b0, 1'b0);
    end
    chk("full count",    32'(bus.count),     32'd8);
    chk("full overflow", 32'(bus.overflow),  32'd1);
    chk("full sum",      32'(bus.sum),       32'd108);
    chk("full head",     32'(bus.out_data),  32'd10);
    chk("full valid",    32'(bus.out_valid), 32'd1);

    // clr alongside an accepted write (full FIFO + pop) while overflow is set.
    cyc(1'b1, 10'd0, 1'b0, 1'b0);
    cyc(1'b0, 10'd0, 1'b0, 1'b0);
    cyc(1'b0, 10'd0, 1'b0, 1'b0);
    cyc(1'b0, 10'd7, 1'b1, 1'b1);
    chk("clr sum",      32'(bus.sum),      32'd7);
    chk("clr overflow", 32'(bus.overflow), 32'd0);
    chk("clr count",    32'(bus.count),    32'd8);
    chk("clr head",     32'(bus.out_data), 32'd11);

    // Repeat of the fill, but the 9th capture meets a pop on the same edge.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      cyc(1'b1 && (i < 9), (i >= 3) ? 10'(10 + i - 3) : 10'd0, 1'b1 && (i == 11), 1'b0);
    end
    chk("fullpop count",    32'(bus.count),    32'd8);
    chk("fullpop overflow", 32'(bus.overflow), 32'd0);
    chk("fullpop sum",      32'(bus.sum),      32'd126);
    chk("fullpop head",     32'(bus.out_data), 32'd11);

    // Async reset with 3 stored and 2 in flight.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1 && (i < 5), (i >= 3) ? 10'(40 + i) : 10'd0, 1'b0, 1'b0);
    end
    chk("midrst pre count", 32'(bus.count), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst out_data",  32'(bus.out_data),  32'd0);
    chk("midrst count",     32'(bus.count),     32'd0);
    chk("midrst sum",       32'(bus.sum),       32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 10'd99, 1'b0, 1'b0);
      chk($sformatf("postrst count c%0d", i), 32'(bus.count), 32'd0);
    end
    chk("postrst out_valid", 32'(bus.out_valid), 32'd0);
    chk("postrst sum",       32'(bus.sum),       32'd0);
    chk("postrst overflow",  32'(bus.overflow),  32'd0);

    // 20 results through the wrapping pointers with random consumer stalls.
    for (int k = 0; k < 20; k++) begin
      vals[k] = 10'($urandom_range(0, 1023));
    end
    pushed = 0; popped = 0; n5 = 0; esum = 16'd0;
    while (!(pushed == 20 && q.size() == 0) && n5 < 400) begin
      iss5 = (n5 % 2 == 0) && (n5 / 2 < 20);
      cap5 = (n5 >= 3) && ((n5 - 3) % 2 == 0) && ((n5 - 3) / 2 < 20);
      f5 = cap5 ? vals[(n5 - 3) / 2] : 10'd0;
      rdy5 = (pushed - popped >= 6) ? 1'b1 : ($urandom_range(0, 3) != 0);
      chk("wrap out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
      if (bus.out_valid && rdy5 && q.size() != 0) begin
        exp_head = q.pop_front();
        chk("wrap order", 32'(bus.out_data), 32'(exp_head));
        popped++;
      end
      if (cap5) begin
        q.push_back(f5);
        pushed++;
        esum = esum + 16'(f5);
      end
      cyc(iss5, f5, rdy5, 1'b0);
      n5++;
    end
    chk("wrap drained in budget", 32'(n5 < 400), 32'd1);
    chk("wrap popped",   32'(popped),       32'd20);
    chk("wrap count",    32'(bus.count),    32'd0);
    chk("wrap overflow", 32'(bus.overflow), 32'd0);
    chk("wrap sum",      32'(bus.sum),      32'(esum));

    // Narrow running sum: 200 + 100 wraps to 44 in 8 bits.
    for (int i = 0; i < 7; i++) begin
      bus8.issue = (i < 2);
      bus8.f_in = (i == 3) ? 10'd200 : ((i == 4) ? 10'd100 : 10'd0);
      bus8.out_ready = 1'b1;
      @(posedge clk);
      #1;
    end
    chk("sumw8 sum",      32'(bus8.sum),      32'd44);
    chk("sumw8 overflow", 32'(bus8.overflow), 32'd0);
    chk("sumw8 count",    32'(bus8.count),    32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
